// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between instruction fetch and load/store.
// Load/store wins ties; after two load/store grants in a row with fetch waiting, fetch gets the slot.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     r_state;
  logic       r_owner_ls;
  logic [1:0] r_cnt;
  logic [1:0] r_ls_streak;

  logic w_last;
  logic w_can_grant;
  logic w_pick_ls;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_read_gnt;

  // A new grant may overlap the final cycle of an outstanding read.
  always_comb begin
    w_last      = (r_state == WAIT) && (r_cnt == LAST_CNT);
    w_can_grant = !rst && ((r_state == IDLE) || w_last);
    w_pick_ls   = ls_req && (!if_req || (r_ls_streak != 2'd2));
    w_ls_gnt    = w_can_grant && w_pick_ls;
    w_if_gnt    = w_can_grant && if_req && !w_pick_ls;
    w_read_gnt  = w_if_gnt || (w_ls_gnt && !ls_we);
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = !rst && w_last && !r_owner_ls;
  assign ls_rvalid = !rst && w_last && r_owner_ls;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (w_if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = {BE_W{1'b1}};
      mem_addr  = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_owner_ls  <= 1'b0;
      r_ls_streak <= 2'd0;
    end else begin
      if (w_read_gnt) begin
        r_state    <= WAIT;
        r_cnt      <= 2'd0;
        r_owner_ls <= w_ls_gnt;
      end else if (r_state == WAIT) begin
        if (w_last) begin
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 2'd1;
        end
      end

      // Streak only grows while fetch is actually being held off.
      if (!if_req || w_if_gnt) begin
        r_ls_streak <= 2'd0;
      end else if (w_ls_gnt && (r_ls_streak != 2'd2)) begin
        r_ls_streak <= r_ls_streak + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a rule-level arbitration model checks grants and the memory bus,
// and a scoreboard of expected read responses is drained by an independent monitor.
module tb_mem_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] img(input int i);
    case (i)
      0:       img = 32'h0050_0093;
      4:       img = 32'hDEAD_BEEF;
      8:       img = 32'hAAAA_AAAA;
      default: img = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  // Physical memory: 16 words, read data appears LAT cycles after the access, junk otherwise.
  logic        load_img = 1'b1;
  logic [31:0] phys [16];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= $urandom;
    if (load_img) begin
      for (int i = 0; i < 16; i++) phys[i] <= img(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) phys[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_pipe[0] <= phys[mem_addr[5:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  logic        g_if = 1'b0, g_ls = 1'b0;
  logic [31:0] last_if_rdata = '0, last_ls_rdata = '0;
  int          n_ls_rv = 0;

  // Reference model: grant legality from "earliest next grant" time plus the streak rule.
  initial begin : model
    int          next_ok;
    int          streak;
    logic [31:0] refm [16];
    logic        can, e_if, e_ls, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    next_ok = 0;
    streak  = 0;
    for (int i = 0; i < 16; i++) refm[i] = img(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ctl", {54'd0, if_gnt, ls_gnt, mem_en, mem_we, mem_be, if_rvalid, ls_rvalid}, 64'd0);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'd0);
        chk("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
        q.delete();
        next_ok = cyc + 1;
        streak  = 0;
      end else begin
        can    = (cyc >= next_ok);
        e_ls   = can && ls_req && (!if_req || streak != 2);
        e_if   = can && if_req && !e_ls;
        e_we   = e_ls && ls_we;
        e_be   = e_if ? 4'hF : (e_ls ? ls_be : 4'h0);
        e_addr = e_if ? if_addr : (e_ls ? ls_addr : 32'd0);
        e_wd   = e_ls ? ls_wdata : 32'd0;
        chk("gnt", {62'd0, if_gnt, ls_gnt}, {62'd0, e_if, e_ls});
        chk("mem_ctl", {58'd0, mem_en, mem_we, mem_be}, {58'd0, e_if || e_ls, e_we, e_be});
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
        if (!e_if) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wd});
        if (e_if) begin
          q.push_back('{1'b0, refm[if_addr[5:2]], cyc + LAT});
          next_ok = cyc + LAT;
        end else if (e_ls && ls_we) begin
          for (int b = 0; b < 4; b++)
            if (ls_be[b]) refm[ls_addr[5:2]][8*b +: 8] = ls_wdata[8*b +: 8];
          next_ok = cyc + 1;
        end else if (e_ls) begin
          q.push_back('{1'b1, refm[ls_addr[5:2]], cyc + LAT});
          next_ok = cyc + LAT;
        end
        if (!if_req || e_if) streak = 0;
        else if (e_ls && streak < 2) streak++;
      end
      g_if = if_gnt;
      g_ls = ls_gnt;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ls_rvalid) begin
          n_ls_rv++;
          last_ls_rdata = ls_rdata;
        end
        if (if_rvalid) last_if_rdata = if_rdata;
        if (if_rvalid || ls_rvalid) begin
          if (q.size() == 0) begin
            chk("rvalid_unexpected", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
          end else begin
            e = q.pop_front();
            chk("rv_cycle", 64'(cyc), 64'(e.due));
            chk("rv_owner", {62'd0, if_rvalid, ls_rvalid}, {62'd0, !e.is_ls, e.is_ls});
            chk("rv_data", {32'd0, e.is_ls ? ls_rdata : if_rdata}, {32'd0, e.data});
            chk("rv_other", {32'd0, e.is_ls ? if_rdata : ls_rdata}, 64'd0);
          end
        end else begin
          if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rv_missing", 64'd0, 64'd1);
          end
          chk("rdata_idle", {if_rdata, ls_rdata}, 64'd0);
        end
      end
    end
  end

  // One driver cycle: retire granted requests, maybe issue new ones, maybe pulse reset.
  task automatic tick(input int p_if, input int p_ls, input int p_st, input int p_rst);
    @(posedge clk);
    #1;
    if (if_req && g_if) if_req = 1'b0;
    if (ls_req && g_ls) ls_req = 1'b0;
    if (!if_req && $urandom_range(99) < p_if) begin
      if_req  = 1'b1;
      if_addr = {26'd0, 4'($urandom), 2'd0};
    end
    if (!ls_req && $urandom_range(99) < p_ls) begin
      ls_req   = 1'b1;
      ls_we    = ($urandom_range(99) < p_st);
      ls_be    = 4'($urandom);
      ls_addr  = {26'd0, 4'($urandom), 2'd0};
      ls_wdata = $urandom;
    end
    rst = ($urandom_range(999) < p_rst);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((if_req || ls_req) && n < 100) begin
      tick(0, 0, 0, 0);
      n++;
    end
    chk("req_timeout", 64'(n < 100), 64'd1);
    repeat (LAT + 1) tick(0, 0, 0, 0);
  endtask

  task automatic drive_ls(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
    int n;
    n = 0;
    while (ls_req && n < 100) begin
      tick(0, 0, 0, 0);
      n++;
    end
    ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = wd;
  endtask

  initial begin
    int rv_before;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    @(posedge clk);
    #1 load_img = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick(0, 0, 0, 0);

    // Single fetch of the first instruction word.
    if_req = 1'b1; if_addr = 32'h0;
    settle();
    chk("fetch0_data", {32'd0, last_if_rdata}, {32'd0, 32'h0050_0093});

    // Simultaneous load and fetch: load first.
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h10; ls_wdata = '0;
    settle();
    chk("both_ld_data", {32'd0, last_ls_rdata}, {32'd0, 32'hDEAD_BEEF});

    // Partial store followed immediately by a load of the same word.
    drive_ls(1'b1, 4'b0011, 32'h20, 32'h1234_5678);
    drive_ls(1'b0, 4'hF, 32'h20, 32'h0);
    settle();
    chk("st_ld_merge", {32'd0, last_ls_rdata}, {32'd0, 32'hAAAA_5678});

    // Reset in the cycle after a load grant drops the response.
    rv_before = n_ls_rv;
    drive_ls(1'b0, 4'hF, 32'h10, 32'h0);
    tick(0, 0, 0, 0);
    rst = 1'b1;
    tick(0, 0, 0, 0);
    repeat (LAT + 2) tick(0, 0, 0, 0);
    chk("rst_drop_rv", 64'(n_ls_rv), 64'(rv_before));
    if_req = 1'b1; if_addr = 32'h8;
    settle();
    chk("fetch_after_rst", {32'd0, last_if_rdata}, {32'd0, img(2)});

    // Saturated load traffic against a waiting fetch, then back-to-back fetches.
    repeat (40) tick(100, 100, 0, 0);
    settle();
    repeat (20) tick(100, 0, 0, 0);
    settle();
    repeat (30) tick(0, 100, 100, 0);
    settle();

    // Mixed random traffic with occasional reset pulses.
    repeat (3000) tick(50, 50, 40, 4);
    rst = 1'b0;
    settle();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
